arf_sequencer: RTL and testbench

Multi-cycle controller for the 16-bit address register file (PC, SP, AR). It accepts one command at a time over a valid/ready handshake and drives the register file's FunSel, RegSel, OutCSel and OutDSel controls, plus memory read/write strobes and byte select, cycle by cycle. It covers instruction fetch, stack push/pop and register loads. It sits between the instruction decoder and the address register file/memory.

---
 rtl/arf_seq_pkg.sv | 57 +++++
 rtl/arf_seq_stack_ctr.sv | 33 +++
 rtl/arf_sequencer.sv | 154 +++++++++++++++
 tb/tb_arf_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_seq_pkg.sv
// Shared encodings for the address-register-file sequencer: opcodes,
// register file control codes, control bundle and FSM states.
package arf_seq_pkg;

    typedef enum logic [2:0] {
        OP_LDPC   = 3'b000,
        OP_FETCH  = 3'b001,
        OP_PUSH   = 3'b010,
        OP_POP    = 3'b011,
        OP_LDAR   = 3'b100,
        OP_LDSP   = 3'b101,
        OP_CLRALL = 3'b110,
        OP_RSVD   = 3'b111
    } op_t;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    localparam logic [2:0] RS_NONE = 3'b000;
    localparam logic [2:0] RS_AR   = 3'b001;
    localparam logic [2:0] RS_SP   = 3'b010;
    localparam logic [2:0] RS_PC   = 3'b100;
    localparam logic [2:0] RS_ALL  = RS_PC | RS_SP | RS_AR;

    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_SP = 2'b01;
    localparam logic [1:0] SEL_AR = 2'b10;

    // Encoding is chosen so that EXECn carries n: the state doubles as the step number.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC1 = 2'd1,
        S_EXEC2 = 2'd2,
        S_EXEC3 = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] reg_sel;
        logic [1:0] fun_sel;
        logic [1:0] outd_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       byte_hi;
    } arf_ctl_t;

    // Number of execute cycles an accepted, non-rejected opcode occupies.
    function automatic logic [1:0] op_len(input op_t op);
        case (op)
            OP_FETCH, OP_PUSH: op_len = 2'd2;
            OP_POP:            op_len = 2'd3;
            default:           op_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/arf_seq_stack_ctr.sv
// Stack word counter, 0..DEPTH; refuses to move past either bound and
// reports full/empty so the sequencer can reject PUSH/POP up front.
module arf_seq_stack_ctr #(
    parameter int DEPTH = 128,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic gclk,
    input  logic grst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic empty
);

    logic [CW-1:0] cnt;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !full) begin
            cnt <= cnt + CW'(1);
        end else if (dec && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/arf_sequencer.sv
// Command sequencer driving the PC/SP/AR register file and memory strobes.
// Define ARF_SEQ_STACK_CHECK_EN to add stack overflow/underflow rejection.
module arf_sequencer
    import arf_seq_pkg::*;
#(
    parameter int STACK_DEPTH = 128
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [2:0]  CmdOp,
    input  logic [15:0] CmdData,
    output logic [15:0] ArfI,
    output logic [1:0]  ArfFunSel,
    output logic [2:0]  ArfRegSel,
    output logic [1:0]  ArfOutCSel,
    output logic [1:0]  ArfOutDSel,
    output logic        MemRd,
    output logic        MemWr,
    output logic        ByteHi,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    state_t     state;
    op_t        op;
    logic       rej;
    logic       reject_now;
    logic [1:0] step;
    logic       last;
    arf_ctl_t   ctl;

`ifdef ARF_SEQ_STACK_CHECK_EN
    logic stk_full, stk_empty;
    logic stk_inc, stk_dec, stk_clr;

    // Counter moves only on the Done edge, so rejected or aborted commands leave it alone.
    assign stk_inc = Done && (op == OP_PUSH);
    assign stk_dec = Done && (op == OP_POP);
    assign stk_clr = Done && ((op == OP_LDSP) || (op == OP_CLRALL));

    arf_seq_stack_ctr #(.DEPTH(STACK_DEPTH)) u_stack_ctr (
        .gclk  (Clock),
        .grst  (Reset),
        .inc   (stk_inc),
        .dec   (stk_dec),
        .clr   (stk_clr),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign reject_now = (CmdOp == OP_RSVD)
                     || ((CmdOp == OP_PUSH) && stk_full)
                     || ((CmdOp == OP_POP)  && stk_empty);
`else
    logic unused_cfg;
    assign unused_cfg = ^STACK_DEPTH;
    assign reject_now = (CmdOp == OP_RSVD);
`endif

    assign step     = state;
    assign last     = (state != S_IDLE) && (step == op_len(op));
    assign CmdReady = (state == S_IDLE);
    assign Busy     = (state != S_IDLE) && !rej;
    assign Done     = last && !rej;
    assign Err      = (state == S_EXEC1) && rej;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            op    <= OP_LDPC;
            rej   <= 1'b0;
            ArfI  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (CmdValid) begin
                        op    <= op_t'(CmdOp);
                        ArfI  <= CmdData;
                        rej   <= reject_now;
                        state <= S_EXEC1;
                    end
                end
                S_EXEC1: state <= (rej || op_len(op) == 2'd1) ? S_IDLE : S_EXEC2;
                S_EXEC2: state <= (op_len(op) == 2'd3) ? S_EXEC3 : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Execute-cycle decode; a rejected command drives nothing.
    always_comb begin
        ctl = '0;
        if (state != S_IDLE && !rej) begin
            case (op)
                OP_LDPC: begin
                    ctl.reg_sel = RS_PC;
                    ctl.fun_sel = FS_LOAD;
                end
                OP_LDAR: begin
                    ctl.reg_sel = RS_AR;
                    ctl.fun_sel = FS_LOAD;
                end
                OP_LDSP: begin
                    ctl.reg_sel = RS_SP;
                    ctl.fun_sel = FS_LOAD;
                end
                OP_CLRALL: begin
                    ctl.reg_sel = RS_ALL;
                    ctl.fun_sel = FS_CLR;
                end
                OP_FETCH: begin
                    ctl.outd_sel = SEL_PC;
                    ctl.mem_rd   = 1'b1;
                    ctl.byte_hi  = (state == S_EXEC2);
                    ctl.reg_sel  = RS_PC;
                    ctl.fun_sel  = FS_INC;
                end
                OP_PUSH: begin
                    // High byte goes to the higher address, written first.
                    ctl.outd_sel = SEL_SP;
                    ctl.mem_wr   = 1'b1;
                    ctl.byte_hi  = (state == S_EXEC1);
                    ctl.reg_sel  = RS_SP;
                    ctl.fun_sel  = FS_DEC;
                end
                OP_POP: begin
                    if (state == S_EXEC1) begin
                        ctl.reg_sel = RS_SP;
                        ctl.fun_sel = FS_INC;
                    end else begin
                        ctl.outd_sel = SEL_SP;
                        ctl.mem_rd   = 1'b1;
                        ctl.byte_hi  = (state == S_EXEC3);
                        ctl.reg_sel  = (state == S_EXEC2) ? RS_SP : RS_NONE;
                        ctl.fun_sel  = (state == S_EXEC2) ? FS_INC : FS_DEC;
                    end
                end
                default: ctl = '0;
            endcase
        end
    end

    assign ArfRegSel  = ctl.reg_sel;
    assign ArfFunSel  = ctl.fun_sel;
    assign ArfOutDSel = ctl.outd_sel;
    assign MemRd      = ctl.mem_rd;
    assign MemWr      = ctl.mem_wr;
    assign ByteHi     = ctl.byte_hi;
    assign ArfOutCSel = (state != S_IDLE) ? SEL_SP : SEL_PC;

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: register-file/memory environment, per-cycle expected
// output queue built from the command table, plus literal end-state checks.
module tb_arf_sequencer;

    localparam logic [2:0] LDPC = 3'b000, FETCH = 3'b001, PUSH = 3'b010, POP = 3'b011;
    localparam logic [2:0] LDAR = 3'b100, LDSP = 3'b101, CLRALL = 3'b110, RSVD = 3'b111;
    localparam int DEPTH = 2;

    logic        Clock = 1'b0, Reset = 1'b1, CmdValid = 1'b0;
    logic [2:0]  CmdOp = '0;
    logic [15:0] CmdData = '0;
    logic        CmdReady, MemRd, MemWr, ByteHi, Busy, Done, Err;
    logic [15:0] ArfI;
    logic [1:0]  ArfFunSel, ArfOutCSel, ArfOutDSel;
    logic [2:0]  ArfRegSel;

    always #5 Clock = ~Clock;

    arf_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdData(CmdData), .ArfI(ArfI), .ArfFunSel(ArfFunSel),
        .ArfRegSel(ArfRegSel), .ArfOutCSel(ArfOutCSel), .ArfOutDSel(ArfOutDSel),
        .MemRd(MemRd), .MemWr(MemWr), .ByteHi(ByteHi), .Busy(Busy), .Done(Done), .Err(Err)
    );

    // Register file environment reacting to the DUT's controls.
    logic [15:0] pc = '0, sp = '0, ar = '0, mem_addr;

    function automatic logic [15:0] upd(input logic [15:0] v, input logic [1:0] fs, input logic [15:0] d);
        case (fs)
            2'b00:   return v - 16'd1;
            2'b01:   return v + 16'd1;
            2'b10:   return d;
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (!Reset) begin
            if (ArfRegSel[2]) pc <= upd(pc, ArfFunSel, ArfI);
            if (ArfRegSel[1]) sp <= upd(sp, ArfFunSel, ArfI);
            if (ArfRegSel[0]) ar <= upd(ar, ArfFunSel, ArfI);
        end
    end

    always_comb begin
        case (ArfOutDSel)
            2'b00:   mem_addr = pc;
            2'b01:   mem_addr = sp;
            default: mem_addr = ar;
        endcase
    end

    typedef struct {
        logic rdy, busy, done, err, rd, wr, hi;
        logic [2:0] rs;
        logic [1:0] fs, cs, ds;
        logic [15:0] addr, arfi;
    } exp_t;

    typedef struct { logic wr; logic hi; logic [15:0] addr; } acc_t;

    exp_t exp_q[$];
    acc_t log_q[$];
    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    // Architectural model: register values and stack depth after each command.
    logic [15:0] m_pc = '0, m_sp = '0, m_ar = '0, m_arfi = '0;
    int m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_v(input logic [15:0] a);
        exp_t e;
        e = '{rdy: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0, rd: 1'b0, wr: 1'b0, hi: 1'b0,
              rs: 3'b000, fs: 2'b00, cs: 2'b00, ds: 2'b00, addr: 16'h0, arfi: a};
        return e;
    endfunction

    function automatic exp_t ex(input logic [2:0] rs, input logic [1:0] fs, input logic [1:0] ds,
                                input logic rd, input logic wr, input logic hi, input logic done,
                                input logic [15:0] addr);
        exp_t e;
        e = '{rdy: 1'b0, busy: 1'b1, done: done, err: 1'b0, rd: rd, wr: wr, hi: hi,
              rs: rs, fs: fs, cs: 2'b01, ds: ds, addr: addr, arfi: m_arfi};
        return e;
    endfunction

    function automatic exp_t rej_v();
        exp_t e;
        e = '{rdy: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b1, rd: 1'b0, wr: 1'b0, hi: 1'b0,
              rs: 3'b000, fs: 2'b00, cs: 2'b01, ds: 2'b00, addr: 16'h0, arfi: m_arfi};
        return e;
    endfunction

    // Per-cycle compare: {rdy,busy,done,err,rd,wr,hi,rs,fs,cs,ds}
    always @(negedge Clock) begin
        exp_t e;
        if (MemRd || MemWr) log_q.push_back('{wr: MemWr, hi: ByteHi, addr: mem_addr});
        if (chk_en) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = idle_v(m_arfi);
            chk("ctl{rdy,busy,done,err,rd,wr,hi,rs,fs,cs,ds}",
                32'({CmdReady, Busy, Done, Err, MemRd, MemWr, ByteHi, ArfRegSel, ArfFunSel, ArfOutCSel, ArfOutDSel}),
                32'({e.rdy, e.busy, e.done, e.err, e.rd, e.wr, e.hi, e.rs, e.fs, e.cs, e.ds}));
            chk("arfi", 32'(ArfI), 32'(e.arfi));
            if (e.rd || e.wr) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clock);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] d, input bit hold);
        bit rj;
        wait_idle();
        @(posedge Clock); #2;
        exp_q.push_back(idle_v(m_arfi));
        m_arfi = d;
        rj = (op == RSVD);
`ifdef ARF_SEQ_STACK_CHECK_EN
        rj = rj || (op == PUSH && m_cnt == DEPTH) || (op == POP && m_cnt == 0);
`endif
        if (rj) exp_q.push_back(rej_v());
        else begin
            case (op)
                LDPC: begin exp_q.push_back(ex(3'b100, 2'b10, 2'b00, 0, 0, 0, 1, 0)); m_pc = d; end
                LDAR: begin exp_q.push_back(ex(3'b001, 2'b10, 2'b00, 0, 0, 0, 1, 0)); m_ar = d; end
                LDSP: begin exp_q.push_back(ex(3'b010, 2'b10, 2'b00, 0, 0, 0, 1, 0)); m_sp = d; m_cnt = 0; end
                CLRALL: begin
                    exp_q.push_back(ex(3'b111, 2'b11, 2'b00, 0, 0, 0, 1, 0));
                    m_pc = 0; m_sp = 0; m_ar = 0; m_cnt = 0;
                end
                FETCH: begin
                    exp_q.push_back(ex(3'b100, 2'b01, 2'b00, 1, 0, 0, 0, m_pc));
                    exp_q.push_back(ex(3'b100, 2'b01, 2'b00, 1, 0, 1, 1, m_pc + 16'd1));
                    m_pc = m_pc + 16'd2;
                end
                PUSH: begin
                    exp_q.push_back(ex(3'b010, 2'b00, 2'b01, 0, 1, 1, 0, m_sp));
                    exp_q.push_back(ex(3'b010, 2'b00, 2'b01, 0, 1, 0, 1, m_sp - 16'd1));
                    m_sp = m_sp - 16'd2; m_cnt++;
                end
                default: begin // POP
                    exp_q.push_back(ex(3'b010, 2'b01, 2'b00, 0, 0, 0, 0, 0));
                    exp_q.push_back(ex(3'b010, 2'b01, 2'b01, 1, 0, 0, 0, m_sp + 16'd1));
                    exp_q.push_back(ex(3'b000, 2'b00, 2'b01, 1, 0, 1, 1, m_sp + 16'd2));
                    m_sp = m_sp + 16'd2; m_cnt--;
                end
            endcase
        end
        CmdValid = 1'b1; CmdOp = op; CmdData = d;
        @(posedge Clock); #2;
        // Keep a different command valid through an execute cycle; it must be ignored.
        if (hold) begin CmdOp = LDPC; CmdData = ~d; @(posedge Clock); #2; end
        CmdValid = 1'b0;
    endtask

    task automatic check_regs();
        wait_idle();
        @(posedge Clock); #2;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("sp", 32'(sp), 32'(m_sp));
        chk("ar", 32'(ar), 32'(m_ar));
    endtask

    task automatic chk_log(input int idx, input logic wr, input logic hi, input logic [15:0] addr);
        if (idx >= log_q.size()) chk("log_missing", 32'(idx), 32'(log_q.size()));
        else chk("log_entry", 32'({log_q[idx].wr, log_q[idx].hi, log_q[idx].addr}), 32'({wr, hi, addr}));
    endtask

    initial begin
        #3;
        chk("rst_outs{rdy,busy,done,err,rs,wr}", 32'({CmdReady, Busy, Done, Err, ArfRegSel, MemWr}), 32'b1000_000_0);
        chk("rst_arfi", 32'(ArfI), 32'h0);
        @(posedge Clock); #2 Reset = 1'b0;

        // Abort a PUSH in its first write cycle.
        @(posedge Clock); #2;
        CmdValid = 1'b1; CmdOp = PUSH; CmdData = 16'h0;
        @(posedge Clock); #2 CmdValid = 1'b0;
        chk("p0_memwr", 32'(MemWr), 32'd1);
        Reset = 1'b1; #1;
        chk("abort{memwr,rdy,busy,rs}", 32'({MemWr, CmdReady, Busy, ArfRegSel}), 32'b0_1_0_000);
        @(posedge Clock); #2 Reset = 1'b0;
        chk_en = 1'b1;

        issue(LDPC, 16'h1234, 0);
        check_regs();
        chk("pc_lit_1234", 32'(pc), 32'h1234);

        issue(LDPC, 16'h0010, 0);
        wait_idle(); log_q.delete();
        issue(FETCH, 16'hAAAA, 1);
        check_regs();
        chk("pc_lit_0012", 32'(pc), 32'h0012);
        chk("fetch_log_len", 32'(log_q.size()), 32'd2);
        chk_log(0, 1'b0, 1'b0, 16'h0010);
        chk_log(1, 1'b0, 1'b1, 16'h0011);

        issue(LDSP, 16'h0100, 0);
        wait_idle(); log_q.delete();
        issue(PUSH, 16'h0, 0);
        check_regs();
        chk("sp_lit_00fe", 32'(sp), 32'h00FE);
        issue(POP, 16'h0, 1);
        check_regs();
        chk("sp_lit_0100", 32'(sp), 32'h0100);
        chk("stack_log_len", 32'(log_q.size()), 32'd4);
        chk_log(0, 1'b1, 1'b1, 16'h0100);
        chk_log(1, 1'b1, 1'b0, 16'h00FF);
        chk_log(2, 1'b0, 1'b0, 16'h00FF);
        chk_log(3, 1'b0, 1'b1, 16'h0100);

        issue(LDAR, 16'hBEEF, 0);
        issue(RSVD, 16'h5555, 0);
        check_regs();
        chk("ar_lit_beef", 32'(ar), 32'hBEEF);

        issue(CLRALL, 16'h0, 0);
        check_regs();

`ifdef ARF_SEQ_STACK_CHECK_EN
        issue(LDSP, 16'h0200, 0);
        wait_idle(); log_q.delete();
        issue(PUSH, 16'h0, 0);
        issue(PUSH, 16'h0, 0);
        issue(PUSH, 16'h0, 0);
        check_regs();
        chk("ovf_sp_lit", 32'(sp), 32'h01FC);
        chk("ovf_writes", 32'(log_q.size()), 32'd4);
        issue(CLRALL, 16'h0, 0);
        wait_idle(); log_q.delete();
        issue(POP, 16'h0, 0);
        check_regs();
        chk("unf_sp_lit", 32'(sp), 32'h0000);
        chk("unf_reads", 32'(log_q.size()), 32'd0);
`else
        issue(LDSP, 16'h0000, 0);
        wait_idle(); log_q.delete();
        issue(PUSH, 16'h0, 0);
        check_regs();
        chk("wrap_sp_lit", 32'(sp), 32'hFFFE);
        chk_log(0, 1'b1, 1'b1, 16'h0000);
        chk_log(1, 1'b1, 1'b0, 16'hFFFF);
`endif

        wait_idle();
        repeat (3) @(posedge Clock);
        #2 chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
